// File: rtl/wbs_charlie7x5_if.sv
// Wishbone slave bus bundle for the 7-pin / 5-column charlieplexed LED driver.
interface wbs_charlie7x5_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [2:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wbs_charlie7x5.sv
// Wishbone-controlled charlieplex scanner: 5x7 framebuffer, one anode pin per phase,
// each phase opened by a single blanking cycle to avoid ghosting between phases.
module wbs_charlie7x5 #(
    parameter int unsigned TICKS_PER_PIN = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wbs_charlie7x5_if.slave       wb,
    output logic [6:0]            charlie7x5_o,
    output logic [6:0]            charlie7x5_oe
);
    localparam int unsigned CW = (TICKS_PER_PIN > 2) ? $clog2(TICKS_PER_PIN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_PIN - 1);

    logic [6:0]    fb_q [5];
    logic [6:0]    fb_d [5];
    logic          en_q, en_d;
    logic          ack_q, ack_d;
    logic [7:0]    dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ph_q, ph_d;
    logic [6:0]    m_q, m_d;
    logic [6:0]    o_q, o_d;
    logic [6:0]    oe_q, oe_d;

    logic          req;
    logic [7:0]    rdata;
    logic [3:0]    k;

    // Bus side: one-cycle ack, write and read-data capture on the ack-raising edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        ack_d = req;
        rdata = '0;
        fb_d  = fb_q;
        en_d  = en_q;
        for (int i = 0; i < 5; i++) begin
            if (wb.wb_adr_i == 3'(i)) rdata = {1'b0, fb_q[i]};
            if (req && wb.wb_we_i && wb.wb_adr_i == 3'(i)) fb_d[i] = wb.wb_dat_i[6:0];
        end
        if (wb.wb_adr_i == 3'd5) rdata = {7'd0, en_q};
        if (req && wb.wb_we_i && wb.wb_adr_i == 3'd5) en_d = wb.wb_dat_i[0];
        dat_d = req ? rdata : dat_q;
    end

    // Scan side: the cathode mask is latched on the blank->drive edge so a phase never tears.
    always_comb begin
        cnt_d = '0;
        ph_d  = '0;
        m_d   = m_q;
        o_d   = '0;
        oe_d  = '0;
        k     = '0;
        if (en_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                ph_d  = (ph_q == 3'd6) ? 3'd0 : ph_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
                ph_d  = ph_q;
            end
            if (cnt_q == '0) begin
                m_d = '0;
                // Cathode of LED (c, ph) sits c+1 pins above the anode, never on the anode itself.
                for (int c = 0; c < 5; c++) begin
                    k = {1'b0, ph_q} + 4'(c + 1);
                    if (k >= 4'd7) k = k - 4'd7;
                    m_d[k[2:0]] = fb_q[c][ph_q];
                end
            end
            if (cnt_d != '0) begin
                o_d  = 7'd1 << ph_d;
                oe_d = o_d | m_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the small framebuffer is reset so the display comes up dark, unlike a RAM.
            fb_q  <= '{default: '0};
            en_q  <= 1'b0;
            ack_q <= 1'b0;
            dat_q <= '0;
            cnt_q <= '0;
            ph_q  <= '0;
            m_q   <= '0;
            o_q   <= '0;
            oe_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            fb_q  <= fb_d;
            en_q  <= en_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            m_q   <= m_d;
            o_q   <= o_d;
            oe_q  <= oe_d;
        end
    end

    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_dat_o   = dat_q;
    assign charlie7x5_o  = o_q;
    assign charlie7x5_oe = oe_q;
endmodule

// File: doc/wbs_charlie7x5.md
WBS_CHARLIE7X5 -- requirements
Module: wbs_charlie7x5

Interface
REQ-001 SHALL have parameter TICKS_PER_PIN, default 1024, meaning clock cycles per scan phase (valid range 2..65535).
REQ-002 SHALL have port clk, input, 1, system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port wb_cyc_i, input, 1, Wishbone bus cycle.
REQ-005 SHALL have port wb_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1, Wishbone write enable.
REQ-007 SHALL have port wb_adr_i, input, 3, register address.
REQ-008 SHALL have port wb_dat_i, input, 8, write data.
REQ-009 SHALL have port wb_dat_o, output, 8, read data.
REQ-010 SHALL have port wb_ack_o, output, 1, Wishbone acknowledge.
REQ-011 SHALL have port charlie7x5_o, output, 7, pin output values.
REQ-012 SHALL have port charlie7x5_oe, output, 7, pin output enables (1 = driven, 0 = hi-Z).

Function
REQ-013 SHALL hold framebuffer fb[0..4] (7 bits each) at addresses 0..4; fb[c] bit r is the LED at column c, row r.
REQ-014 SHALL hold CTRL at address 5: bit 0 = scan enable; other bits read 0.
REQ-015 SHALL ignore writes to addresses 6..7 and return 0 on reads of them; written data bit 7 of fb registers is discarded and reads back 0.
REQ-016 SHALL assert wb_ack_o for exactly one cycle, the cycle after wb_cyc_i & wb_stb_i are sampled high while wb_ack_o is low; no ack is generated in the cycle ack is already high.
REQ-017 SHALL perform register writes on the same edge that raises wb_ack_o; wb_dat_o SHALL be valid while wb_ack_o is high.
REQ-018 SHALL map LED (c,r) to anode pin r and cathode pin k = (r + c + 1) mod 7.
REQ-019 SHALL keep a tick counter cnt (0..TICKS_PER_PIN-1) and phase ph (0..6); cnt wraps to 0 after TICKS_PER_PIN-1 and ph advances, wrapping 6 -> 0.
REQ-020 SHALL register outputs on the same edge that updates cnt/ph: while cnt == 0, o = 0 and oe = 0 (blanking).
REQ-021 SHALL, while cnt != 0, drive o = 1<<ph and oe = (1<<ph) | M, where M bit k = fb[(k-ph-1) mod 7][ph] for (k-ph-1) mod 7 in 0..4, else 0.
REQ-022 SHALL sample M from fb on the edge moving cnt 0 -> 1 and hold it for the rest of the phase; fb writes mid-phase take effect next phase.
REQ-023 SHALL, while enable = 0, hold cnt = 0, ph = 0, o = 0, oe = 0.
REQ-024 SHALL, when enable is cleared mid-phase, blank outputs and reset cnt/ph on the edge after the write edge; setting enable starts at ph 0, cnt 0 (blank cycle first).
REQ-025 SHALL never drive oe with an all-cathode pattern having the anode bit clear while o != 0.

Reset
REQ-026 SHALL, with rst_n low at a clock edge, set fb[0..4] = 0, enable = 0, cnt = 0, ph = 0, wb_ack_o = 0, wb_dat_o = 0, charlie7x5_o = 0, charlie7x5_oe = 0.
REQ-027 SHALL let reset override any in-progress bus cycle; no ack is produced for a request sampled in the reset cycle.

Verification
REQ-028 Reset: rst_n low 2 cycles, then high -> all outputs 0, reads of addresses 0..5 return 8'h00.
REQ-029 Bus: write 8'hFF to addr 2, read addr 2 -> 8'h7F; write addr 6, read addr 6 -> 8'h00; each access acks exactly one cycle.
REQ-030 Scan (TICKS_PER_PIN=4): fb[0]=8'h01, enable=1 -> phase 0: 1 cycle o=0/oe=0, then 3 cycles o=7'h01, oe=7'h03; phases 1..6 drive o=1<<ph, oe=1<<ph only; period 28 cycles.
REQ-031 Mapping: fb[4]=8'h40 only -> during phase 6 o=7'h40, oe=7'h50 (cathode pin 4).
REQ-032 Mid-phase write: fb[0] changed during phase 0 driving -> oe unchanged until next phase-0 drive, then reflects new value.
REQ-033 Disable/reset mid-scan: clear enable, or pull rst_n low, during phase 3 -> outputs 0 next edge; re-enable -> scan restarts at phase 0 with blank cycle.
